// File: rtl/tile_ram_dp.sv
// tile_ram_dp: dual-port byte-lane RAM with a hardware clear sequence
// and a selectable read-during-write mode and output register.
module tile_ram_dp #(
    parameter int A = 10,
    parameter int D = 8,
    parameter int B = 8,
    parameter int RDW = 0,
    parameter int OUT_REG = 0,
    parameter logic [D-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    output logic             busy,
    input  logic             wr_en,
    input  logic [A-1:0]     wr_addr,
    input  logic [D-1:0]     wr_data,
    input  logic [D/B-1:0]   wr_be,
    input  logic             rd_en,
    input  logic [A-1:0]     rd_addr,
    output logic [D-1:0]     rd_data,
    output logic             rd_valid
);
    localparam int NB = D / B;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t state, state_n;
    logic [A-1:0] cnt, cnt_n;
    logic [D-1:0] mem [2**A];
    logic [D-1:0] rd_word, d1;
    logic wr_acc, rd_acc, v1;

    assign busy   = state == CLEAR;
    assign wr_acc = wr_en && !busy;
    assign rd_acc = rd_en && !busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == IDLE && clr) begin
            state_n = CLEAR;
            cnt_n   = '0;
        end else if (state == CLEAR) begin
            cnt_n   = cnt + A'(1);
            state_n = cnt == {A{1'b1}} ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy)
                mem[cnt] <= CLR_VAL;
            else if (wr_en)
                for (int i = 0; i < NB; i++)
                    if (wr_be[i]) mem[wr_addr][i*B +: B] <= wr_data[i*B +: B];
        end
    end

    // New-data mode merges only the enabled lanes of a colliding write.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW != 0 && wr_acc && wr_addr == rd_addr)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) rd_word[i*B +: B] = wr_data[i*B +: B];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= rd_acc;
            if (rd_acc) d1 <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [D-1:0] d2;
            logic v2;
            always_ff @(posedge clk) begin
                if (reset) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end
            assign rd_data  = d2;
            assign rd_valid = v2;
        end else begin : g_dir
            assign rd_data  = d1;
            assign rd_valid = v1;
        end
    endgenerate
endmodule

// File: tb/tb_tile_ram_dp.sv
// tb_tile_ram_dp: directed bench driving two configurations in lockstep,
// u0 (OUT_REG=0, RDW=0) and u1 (OUT_REG=1, RDW=1).
module tb_tile_ram_dp;
    logic clk = 0, reset = 1, clr = 0, wr_en = 0, rd_en = 0;
    logic [3:0] wr_addr = 0, rd_addr = 0;
    logic [15:0] wr_data = 0;
    logic [1:0] wr_be = 0;
    logic busy0, busy1, v0, v1;
    logic [15:0] q0, q1;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    tile_ram_dp #(.A(4), .D(16), .B(8), .RDW(0), .OUT_REG(0), .CLR_VAL(16'h0000)) u0 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy0), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(q0), .rd_valid(v0));
    tile_ram_dp #(.A(4), .D(16), .B(8), .RDW(1), .OUT_REG(1), .CLR_VAL(16'h0000)) u1 (
        .clk(clk), .reset(reset), .clr(clr), .busy(busy1), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(q1), .rd_valid(v1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_read(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        check({tag, "_v0"}, v0, 1);
        check({tag, "_q0"}, q0, e0);
        check({tag, "_v1early"}, v1, 0);
        tick();
        check({tag, "_v0late"}, v0, 0);
        check({tag, "_v1"}, v1, 1);
        check({tag, "_q1"}, q1, e1);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] e0, input logic [15:0] e1);
        rd_en = 1; rd_addr = a;
        tick();
        rd_en = 0;
        finish_read(tag, e0, e1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 0;
    endtask

    task automatic do_rw(input string tag, input logic [3:0] wa, input logic [15:0] d, input logic [1:0] be,
                         input logic [3:0] ra, input logic [15:0] e0, input logic [15:0] e1);
        wr_en = 1; wr_addr = wa; wr_data = d; wr_be = be;
        rd_en = 1; rd_addr = ra;
        tick();
        wr_en = 0; rd_en = 0;
        finish_read(tag, e0, e1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            tick();
        end
    endtask

    int n;
    logic bad;

    initial begin
        tick(); tick();
        check("rst_busy0", busy0, 1);
        check("rst_busy1", busy1, 1);
        check("rst_v", {v0, v1}, 0);
        check("rst_q", {q0, q1}, 0);
        reset = 0;
        count_busy(n);
        check("init_busy_len", n, 16);
        check("init_busy1", busy1, 0);
        for (int i = 0; i < 16; i++) do_read("init_rd", 4'(i), 16'h0000, 16'h0000);

        do_write(3, 16'hABCD, 2'b11);
        do_read("wr_full", 3, 16'hABCD, 16'hABCD);
        tick();
        check("hold_q0", q0, 16'hABCD);
        check("hold_q1", q1, 16'hABCD);
        do_write(3, 16'h1234, 2'b01);
        do_read("wr_lane0", 3, 16'hAB34, 16'hAB34);
        do_write(3, 16'hFFFF, 2'b00);
        do_read("wr_be0", 3, 16'hAB34, 16'hAB34);

        do_write(5, 16'h1111, 2'b11);
        do_rw("rdw_full", 5, 16'h2222, 2'b11, 5, 16'h1111, 16'h2222);
        do_write(5, 16'h1111, 2'b11);
        do_rw("rdw_lane1", 5, 16'h2222, 2'b10, 5, 16'h1111, 16'h2211);
        do_read("after_lane1", 5, 16'h2211, 16'h2211);
        do_rw("diff_addr", 7, 16'h7777, 2'b11, 3, 16'hAB34, 16'hAB34);

        rd_en = 1; rd_addr = 3;
        tick();
        check("b2b_v0a", v0, 1);
        check("b2b_q0a", q0, 16'hAB34);
        rd_addr = 7;
        tick();
        rd_en = 0;
        check("b2b_q0b", q0, 16'h7777);
        check("b2b_v1a", v1, 1);
        check("b2b_q1a", q1, 16'hAB34);
        tick();
        check("b2b_v0end", v0, 0);
        check("b2b_v1b", v1, 1);
        check("b2b_q1b", q1, 16'h7777);

        clr = 1; rd_en = 1; rd_addr = 3;
        tick();
        clr = 0; rd_en = 0;
        n = 0; bad = 0;
        while (busy0 && n < 40) begin
            n++;
            if (n == 1) begin
                check("clr_rd_v0", v0, 1);
                check("clr_rd_q0", q0, 16'hAB34);
            end else if (n == 2) begin
                check("clr_rd_v1", v1, 1);
                check("clr_rd_q1", q1, 16'hAB34);
            end else if (v0 || v1) bad = 1;
            clr = n == 5;
            wr_en = n == 10; wr_addr = 2; wr_data = 16'h5A5A; wr_be = 2'b11;
            rd_en = n == 10; rd_addr = 3;
            tick();
        end
        clr = 0; wr_en = 0; rd_en = 0;
        check("clr_busy_len", n, 16);
        check("clr_no_valid", bad, 0);
        do_read("clr_a2", 2, 16'h0000, 16'h0000);
        do_read("clr_a3", 3, 16'h0000, 16'h0000);
        do_read("clr_a5", 5, 16'h0000, 16'h0000);
        do_read("clr_a7", 7, 16'h0000, 16'h0000);

        do_write(9, 16'h9999, 2'b11);
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 6; i++) tick();
        reset = 1;
        tick();
        check("midrst_busy", {busy0, busy1}, 2'b11);
        check("midrst_v", {v0, v1}, 0);
        check("midrst_q", {q0, q1}, 0);
        reset = 0;
        count_busy(n);
        check("restart_busy_len", n, 16);
        do_read("restart_a9", 9, 16'h0000, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
